// File: rtl/fpu_f2i_converter.sv
// Iterative IEEE-754 single to int32/uint32 converter.
// One mantissa bit shifted per cycle, then a single round/saturate step.
`timescale 1ns/1ps
module fpu_f2i_converter #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 5
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [XLEN-1:0] in_data,
   input  logic            in_round,
   input  logic            in_signed,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_data,
   output logic            out_invalid,
   output logic            out_inexact
);

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      ROUND,
      DONE
   } state_t;

   state_t state_q, state_d;

   logic [XLEN-1:0]  mag_q, mag_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             guard_q, guard_d;
   logic             sticky_q, sticky_d;
   logic             sign_q, sign_d;
   logic             rnd_q, rnd_d;
   logic             sgn_q, sgn_d;
   logic             left_q, left_d;
   logic             nan_q, nan_d;
   logic             ovf_q, ovf_d;
   logic [XLEN-1:0]  od_q, od_d;
   logic             inv_q, inv_d;
   logic             inx_q, inx_d;

   logic [7:0]       exp_w;
   logic [22:0]      frac_w;
   logic [7:0]       shamt;
   logic             inc;
   logic [XLEN:0]    m33;
   logic [XLEN-1:0]  neg;

   assign exp_w  = in_data[30:23];
   assign frac_w = in_data[22:0];

   assign in_ready    = (state_q == IDLE) && !rst;
   assign out_valid   = (state_q == DONE);
   assign out_data    = od_q;
   assign out_invalid = inv_q;
   assign out_inexact = inx_q;

   // Next-state, datapath and result computation
   always_comb begin
      state_d  = state_q;
      mag_d    = mag_q;
      cnt_d    = cnt_q;
      guard_d  = guard_q;
      sticky_d = sticky_q;
      sign_d   = sign_q;
      rnd_d    = rnd_q;
      sgn_d    = sgn_q;
      left_d   = left_q;
      nan_d    = nan_q;
      ovf_d    = ovf_q;
      od_d     = od_q;
      inv_d    = inv_q;
      inx_d    = inx_q;
      shamt    = 8'd0;
      inc      = rnd_q & guard_q & (sticky_q | mag_q[0]);
      m33      = {1'b0, mag_q} + {{XLEN{1'b0}}, inc};
      neg      = ~m33[XLEN-1:0] + 32'd1;

      unique case (state_q)
         IDLE: begin
            if (in_valid && in_ready) begin
               sign_d   = in_data[31];
               rnd_d    = in_round;
               sgn_d    = in_signed;
               mag_d    = {8'b0, 1'b1, frac_w};
               guard_d  = 1'b0;
               sticky_d = 1'b0;
               nan_d    = 1'b0;
               ovf_d    = 1'b0;
               left_d   = 1'b0;
               if (exp_w == 8'd255) begin
                  mag_d = '0;
                  nan_d = (frac_w != 23'd0);
                  ovf_d = (frac_w == 23'd0);
               end else if (exp_w == 8'd0) begin
                  mag_d    = '0;
                  sticky_d = (frac_w != 23'd0);
               end else if (exp_w >= 8'd159) begin
                  mag_d = '0;
                  ovf_d = 1'b1;
               end else if (exp_w >= 8'd150) begin
                  left_d = 1'b1;
                  shamt  = exp_w - 8'd150;
               end else begin
                  shamt = 8'd150 - exp_w;
                  if (shamt > 8'd25) begin
                     shamt = 8'd25;
                  end
               end
               cnt_d   = shamt[CNT_W-1:0];
               state_d = (shamt != 8'd0) ? SHIFT : ROUND;
            end
         end
         SHIFT: begin
            if (left_q) begin
               mag_d = mag_q << 1;
            end else begin
               mag_d    = mag_q >> 1;
               guard_d  = mag_q[0];
               sticky_d = sticky_q | guard_q;
            end
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               state_d = ROUND;
            end
         end
         ROUND: begin
            inv_d   = 1'b0;
            inx_d   = guard_q | sticky_q;
            state_d = DONE;
            if (nan_q) begin
               od_d  = sgn_q ? 32'h7FFF_FFFF : 32'hFFFF_FFFF;
               inv_d = 1'b1;
               inx_d = 1'b0;
            end else if (ovf_q) begin
               if (sgn_q) begin
                  od_d = sign_q ? 32'h8000_0000 : 32'h7FFF_FFFF;
               end else begin
                  od_d = sign_q ? 32'h0000_0000 : 32'hFFFF_FFFF;
               end
               inv_d = 1'b1;
               inx_d = 1'b0;
            end else if (sgn_q) begin
               if (!sign_q && m33 > 33'h0_7FFF_FFFF) begin
                  od_d  = 32'h7FFF_FFFF;
                  inv_d = 1'b1;
                  inx_d = 1'b0;
               end else if (sign_q && m33 > 33'h0_8000_0000) begin
                  od_d  = 32'h8000_0000;
                  inv_d = 1'b1;
                  inx_d = 1'b0;
               end else begin
                  od_d = sign_q ? neg : m33[XLEN-1:0];
               end
            end else begin
               if (sign_q && m33 != '0) begin
                  od_d  = '0;
                  inv_d = 1'b1;
                  inx_d = 1'b0;
               end else if (m33[XLEN]) begin
                  od_d  = 32'hFFFF_FFFF;
                  inv_d = 1'b1;
                  inx_d = 1'b0;
               end else begin
                  od_d = m33[XLEN-1:0];
               end
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers; reset aborts any conversion
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         mag_q    <= '0;
         cnt_q    <= '0;
         guard_q  <= 1'b0;
         sticky_q <= 1'b0;
         sign_q   <= 1'b0;
         rnd_q    <= 1'b0;
         sgn_q    <= 1'b0;
         left_q   <= 1'b0;
         nan_q    <= 1'b0;
         ovf_q    <= 1'b0;
         od_q     <= '0;
         inv_q    <= 1'b0;
         inx_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         mag_q    <= mag_d;
         cnt_q    <= cnt_d;
         guard_q  <= guard_d;
         sticky_q <= sticky_d;
         sign_q   <= sign_d;
         rnd_q    <= rnd_d;
         sgn_q    <= sgn_d;
         left_q   <= left_d;
         nan_q    <= nan_d;
         ovf_q    <= ovf_d;
         od_q     <= od_d;
         inv_q    <= inv_d;
         inx_q    <= inx_d;
      end
   end

endmodule

// File: tb/tb_fpu_f2i_converter.sv
// Directed bench for fpu_f2i_converter.
// Vectors carry hand-derived results and latencies.
`timescale 1ns/1ps
module tb_fpu_f2i_converter;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic        in_round;
   logic        in_signed;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic        out_invalid;
   logic        out_inexact;

   int checks = 0;
   int failures = 0;

   typedef struct {
      logic [31:0] f;
      logic        rnd;
      logic        sgn;
      logic [31:0] d;
      logic        inv;
      logic        inx;
      int          lat;
   } vec_t;

   fpu_f2i_converter #(.XLEN(32), .CNT_W(5)) dut (
      .clk(clk),
      .rst(rst),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .in_data(in_data),
      .in_round(in_round),
      .in_signed(in_signed),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data(out_data),
      .out_invalid(out_invalid),
      .out_inexact(out_inexact)
   );

   always #5 clk = ~clk;

   task automatic convert(input logic [31:0] f, input logic rnd,
                          input logic sgn, input bit ack,
                          output logic [31:0] d, output logic inv,
                          output logic inx, output int lat);
      in_data   = f;
      in_round  = rnd;
      in_signed = sgn;
      in_valid  = 1'b1;
      @(posedge clk);
      #1;
      in_valid  = 1'b0;
      in_data   = 32'hDEAD_BEEF;
      in_round  = ~rnd;
      in_signed = ~sgn;
      lat = 0;
      while (!out_valid && lat < 100) begin
         @(posedge clk);
         #1;
         lat++;
      end
      checks++;
      if (!out_valid) begin
         failures++;
         $display("FAIL timeout op=%h out_valid=%b required=1", f, out_valid);
      end
      d   = out_data;
      inv = out_invalid;
      inx = out_inexact;
      if (ack) begin
         out_ready = 1'b1;
         @(posedge clk);
         #1;
         out_ready = 1'b0;
      end
   endtask

   task automatic test_reset;
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      in_round  = 1'b0;
      in_signed = 1'b0;
      out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b0) begin
         failures++;
         $display("FAIL rst_valid got=%b exp=0", out_valid);
      end
      checks++;
      if (out_data !== 32'h0 || out_invalid !== 1'b0 || out_inexact !== 1'b0) begin
         failures++;
         $display("FAIL rst_outs got=%h/%b/%b exp=0/0/0",
                  out_data, out_invalid, out_inexact);
      end
      checks++;
      if (in_ready !== 1'b0) begin
         failures++;
         $display("FAIL rst_ready_in_reset got=%b exp=0", in_ready);
      end
      rst = 1'b0;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         failures++;
         $display("FAIL rst_ready_after got=%b exp=1", in_ready);
      end
   endtask

   task automatic test_basic;
      vec_t v[5];
      logic [31:0] d;
      logic inv, inx;
      int lat;
      v[0] = '{32'h404CCCCD, 1'b1, 1'b1, 32'd3,         1'b0, 1'b1, 23};
      v[1] = '{32'hC1F1999A, 1'b0, 1'b1, 32'hFFFFFFE2,  1'b0, 1'b1, 20};
      v[2] = '{32'hC1F1999A, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 20};
      v[3] = '{32'h3F800000, 1'b1, 1'b1, 32'd1,         1'b0, 1'b0, 24};
      v[4] = '{32'h4B000000, 1'b0, 1'b0, 32'h00800000,  1'b0, 1'b0, 1};
      for (int i = 0; i < 5; i++) begin
         convert(v[i].f, v[i].rnd, v[i].sgn, 1'b1, d, inv, inx, lat);
         checks++;
         if (d !== v[i].d) begin
            failures++;
            $display("FAIL basic[%0d] data got=%h exp=%h", i, d, v[i].d);
         end
         checks++;
         if (inv !== v[i].inv || inx !== v[i].inx) begin
            failures++;
            $display("FAIL basic[%0d] flags got=%b%b exp=%b%b",
                     i, inv, inx, v[i].inv, v[i].inx);
         end
         checks++;
         if (lat !== v[i].lat) begin
            failures++;
            $display("FAIL basic[%0d] latency got=%0d exp=%0d", i, lat, v[i].lat);
         end
      end
   endtask

   task automatic test_ties;
      vec_t v[4];
      logic [31:0] d;
      logic inv, inx;
      int lat;
      v[0] = '{32'h40200000, 1'b1, 1'b1, 32'd2, 1'b0, 1'b1, 23};
      v[1] = '{32'h40600000, 1'b1, 1'b1, 32'd4, 1'b0, 1'b1, 23};
      v[2] = '{32'h3F000000, 1'b1, 1'b1, 32'd0, 1'b0, 1'b1, 25};
      v[3] = '{32'h40200000, 1'b0, 1'b1, 32'd2, 1'b0, 1'b1, 23};
      for (int i = 0; i < 4; i++) begin
         convert(v[i].f, v[i].rnd, v[i].sgn, 1'b1, d, inv, inx, lat);
         checks++;
         if (d !== v[i].d) begin
            failures++;
            $display("FAIL ties[%0d] data got=%h exp=%h", i, d, v[i].d);
         end
         checks++;
         if (inv !== v[i].inv || inx !== v[i].inx) begin
            failures++;
            $display("FAIL ties[%0d] flags got=%b%b exp=%b%b",
                     i, inv, inx, v[i].inv, v[i].inx);
         end
         checks++;
         if (lat !== v[i].lat) begin
            failures++;
            $display("FAIL ties[%0d] latency got=%0d exp=%0d", i, lat, v[i].lat);
         end
      end
   endtask

   task automatic test_bounds;
      vec_t v[4];
      logic [31:0] d;
      logic inv, inx;
      int lat;
      v[0] = '{32'h4F000000, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b0, 9};
      v[1] = '{32'h4F000000, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b0, 9};
      v[2] = '{32'hCF000000, 1'b1, 1'b1, 32'h80000000, 1'b0, 1'b0, 9};
      v[3] = '{32'h4F800000, 1'b0, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0, 1};
      for (int i = 0; i < 4; i++) begin
         convert(v[i].f, v[i].rnd, v[i].sgn, 1'b1, d, inv, inx, lat);
         checks++;
         if (d !== v[i].d) begin
            failures++;
            $display("FAIL bounds[%0d] data got=%h exp=%h", i, d, v[i].d);
         end
         checks++;
         if (inv !== v[i].inv || inx !== v[i].inx) begin
            failures++;
            $display("FAIL bounds[%0d] flags got=%b%b exp=%b%b",
                     i, inv, inx, v[i].inv, v[i].inx);
         end
         checks++;
         if (lat !== v[i].lat) begin
            failures++;
            $display("FAIL bounds[%0d] latency got=%0d exp=%0d", i, lat, v[i].lat);
         end
      end
   endtask

   task automatic test_specials;
      vec_t v[6];
      logic [31:0] d;
      logic inv, inx;
      int lat;
      v[0] = '{32'h7FC00000, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b0, 1};
      v[1] = '{32'h7FC00000, 1'b0, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0, 1};
      v[2] = '{32'hFF800000, 1'b0, 1'b1, 32'h80000000, 1'b1, 1'b0, 1};
      v[3] = '{32'h00000001, 1'b1, 1'b1, 32'h0,        1'b0, 1'b1, 1};
      v[4] = '{32'hBF400000, 1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 25};
      v[5] = '{32'h80000000, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1};
      for (int i = 0; i < 6; i++) begin
         convert(v[i].f, v[i].rnd, v[i].sgn, 1'b1, d, inv, inx, lat);
         checks++;
         if (d !== v[i].d) begin
            failures++;
            $display("FAIL special[%0d] data got=%h exp=%h", i, d, v[i].d);
         end
         checks++;
         if (inv !== v[i].inv || inx !== v[i].inx) begin
            failures++;
            $display("FAIL special[%0d] flags got=%b%b exp=%b%b",
                     i, inv, inx, v[i].inv, v[i].inx);
         end
         checks++;
         if (lat !== v[i].lat) begin
            failures++;
            $display("FAIL special[%0d] latency got=%0d exp=%0d", i, lat, v[i].lat);
         end
      end
   endtask

   task automatic test_hold;
      logic [31:0] d;
      logic inv, inx;
      int lat;
      bit seen;
      convert(32'h3F800000, 1'b0, 1'b1, 1'b0, d, inv, inx, lat);
      in_valid = 1'b1;
      in_data  = 32'h40600000;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         checks++;
         if (out_valid !== 1'b1 || out_data !== 32'd1 ||
             out_invalid !== 1'b0 || out_inexact !== 1'b0) begin
            failures++;
            $display("FAIL hold[%0d] got=%b/%h/%b/%b exp=1/00000001/0/0",
                     i, out_valid, out_data, out_invalid, out_inexact);
         end
         checks++;
         if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL hold_ready[%0d] got=%b exp=0", i, in_ready);
         end
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         failures++;
         $display("FAIL release got valid=%b ready=%b exp valid=0 ready=1",
                  out_valid, in_ready);
      end
      seen = 1'b0;
      repeat (30) begin
         @(posedge clk);
         #1;
         if (out_valid) seen = 1'b1;
      end
      checks++;
      if (seen !== 1'b0) begin
         failures++;
         $display("FAIL hold_no_accept got=%b exp=0", seen);
      end
   endtask

   task automatic test_reset_mid_shift;
      logic [31:0] d;
      logic inv, inx;
      int lat;
      bit seen;
      in_data   = 32'h404CCCCD;
      in_round  = 1'b1;
      in_signed = 1'b1;
      in_valid  = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
         failures++;
         $display("FAIL midrst got valid=%b ready=%b exp 0/0", out_valid, in_ready);
      end
      rst = 1'b0;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         failures++;
         $display("FAIL midrst_ready got=%b exp=1", in_ready);
      end
      seen = 1'b0;
      repeat (30) begin
         @(posedge clk);
         #1;
         if (out_valid) seen = 1'b1;
      end
      checks++;
      if (seen !== 1'b0) begin
         failures++;
         $display("FAIL midrst_stale got=%b exp=0", seen);
      end
      convert(32'h40600000, 1'b1, 1'b1, 1'b1, d, inv, inx, lat);
      checks++;
      if (d !== 32'd4 || inv !== 1'b0 || inx !== 1'b1 || lat !== 23) begin
         failures++;
         $display("FAIL midrst_next got=%h/%b/%b/%0d exp=00000004/0/1/23",
                  d, inv, inx, lat);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_ties();
      test_bounds();
      test_specials();
      test_hold();
      test_reset_mid_shift();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fpu_f2i_converter.md
Name: fpu_f2i_converter

Overview:
Downstream consumer of the FPU result word. It converts an IEEE-754 single-precision value (FPU `result`) to a 32-bit signed or unsigned integer. Conversion is iterative, shifting the mantissa one bit per cycle, with truncate or round-to-nearest-even rounding, saturation, and invalid/inexact flags. Valid/ready handshake on both sides.

Parameters:
XLEN, 32, width of float input and integer output; only 32 is supported.
CNT_W, 5, shift-counter width; must hold a value of at least 25.

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
in_valid  input  1  float operand valid
in_ready  output  1  converter idle and able to accept
in_data  input  XLEN  IEEE-754 single operand (FPU result)
in_round  input  1  0 = truncate toward zero, 1 = round-nearest-even
in_signed  input  1  1 = signed int32 target, 0 = unsigned uint32 target
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
out_data  output  XLEN  integer result
out_invalid  output  1  NaN, infinity or out-of-range input (saturated)
out_inexact  output  1  nonzero bits were discarded by rounding; 0 whenever invalid

Behaviour:
- Reset (rst=1 at an edge): state=IDLE; out_valid=0, out_data=0, out_invalid=0, out_inexact=0. Aborts any conversion in progress and drops its result. in_ready = (state==IDLE) && !rst.
- FSM states: IDLE, SHIFT, ROUND, DONE.
- IDLE: on in_valid && in_ready, latch sign, round mode and signedness. Load m={hidden,frac} (24b). Set E = exp-127.
- Shift count S is decided at accept:
  - exp==255: S=0. Result is a NaN, or an infinity saturated by sign.
  - exp==0 (zero or denormal): S=0. Magnitude 0; sticky=(frac!=0).
  - E>=32: S=0, overflow.
  - 23<=E<=31: left shift, S=E-23.
  - E<23: right shift, S=min(23-E,25).
- Next state after accept: SHIFT if S>0, else ROUND.
- SHIFT: one bit per cycle; counter decrements to 0, then ROUND.
  - Right shift: guard=bit shifted out, sticky|=old guard. Guard and sticky are cleared at accept.
  - Left shift: zero fill; 32-bit working register.
- ROUND: one cycle.
  - RNE: increment if guard && (sticky || lsb). Truncate: no increment.
  - inexact = guard || sticky.
  - Apply sign and saturation on a 33-bit magnitude, then go to DONE with out_valid=1.
- Latency: an accept at edge k gives out_valid high after edge k+S+1. Examples: 1 cycle for NaN/zero, 23 cycles for E=1.
- Saturation and invalid:
  - Signed: magnitude > 2^31-1 gives 0x7FFFFFFF (positive) or 0x80000000 (negative), invalid. Exactly -2^31 is valid, exact.
  - Unsigned: magnitude > 2^32-1 gives 0xFFFFFFFF, invalid. A negative value that rounds to nonzero magnitude gives 0, invalid. A negative value rounding to 0 gives 0, inexact only.
  - NaN: 0x7FFFFFFF signed, 0xFFFFFFFF unsigned, invalid. Infinity is treated as overflow by sign.
- Negative signed result is the two's complement of the magnitude.
- DONE: outputs held stable while out_ready=0. On out_valid && out_ready go to IDLE; out_valid falls on that edge. No new input is accepted before IDLE; in_ready=0 in SHIFT/ROUND/DONE.
- in_data, in_round and in_signed are ignored when not accepted. Input changes after accept do not affect the result.

Test Plan:
- 0x404CCCCD (3.2), RNE, signed: out_data=3, inexact=1, invalid=0; out_valid exactly 23 cycles after accept.
- 0xC1F1999A (-30.2), truncate, signed: out_data=0xFFFFFFE2, inexact=1. Same operand with unsigned: out_data=0, invalid=1.
- Ties, RNE, signed: 0x40200000 (2.5) gives 2; 0x40600000 (3.5) gives 4; 0x3F000000 (0.5) gives 0. All inexact=1. 0x40200000 with truncate gives 2.
- Boundaries:
  - 0x4F000000 (2^31) signed: 0x7FFFFFFF, invalid. Unsigned: 0x80000000, no flags, latency 9.
  - 0xCF000000 signed: 0x80000000, no flags.
  - 0x4F800000 unsigned: 0xFFFFFFFF, invalid.
- Specials:
  - 0x7FC00000 signed: 0x7FFFFFFF, invalid, latency 1.
  - 0xFF800000 signed: 0x80000000, invalid.
  - 0x00000001 (denormal): 0, inexact=1.
  - 0xBF400000 (-0.75) RNE unsigned: 0, invalid=1.
- Handshake and reset:
  - Hold out_ready=0 for 5 cycles: out_data and flags stable, in_ready=0. Raise out_ready: in_ready=1 the next cycle.
  - Assert rst mid-SHIFT: after that edge out_valid=0, state IDLE. in_ready=1 once rst=0, and a new operand converts correctly.
